// File: rtl/result_display.sv
// 6-bit ALU result to multiplexed 4-digit seven-segment display.
// A double-dabble converter refreshes the digit registers; a scan counter multiplexes the digits.
module result_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] x,
  input  logic       signed_mode,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       busy
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [6:0]  in_q, in_d;
  logic [6:0]  last_q, last_d;
  logic [13:0] sr_q, sr_d;
  logic [2:0]  iter_q, iter_d;
  logic        neg_q, neg_d;
  logic [3:0]  ones_q, ones_d, tens_q, tens_d;
  logic        dneg_q, dneg_d;
  logic        conv_valid_q, conv_valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        busy_q, busy_d;
  logic        in_neg;
  logic [5:0]  in_mag;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  // sr layout: {tens[13:10], ones[9:6], binary[5:0]}
  function automatic logic [13:0] dd_step(input logic [13:0] s);
    logic [13:0] t;
    t = s;
    if (t[9:6] >= 4'd5)   t[9:6]   = t[9:6] + 4'd3;
    if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
    return {t[12:0], 1'b0};
  endfunction

  assign in_neg = in_q[6] & in_q[5];
  assign in_mag = in_neg ? (6'd0 - in_q[5:0]) : in_q[5:0];

  always_comb begin
    in_d         = {signed_mode, x};
    state_d      = state_q;
    last_d       = last_q;
    sr_d         = sr_q;
    iter_d       = iter_q;
    neg_d        = neg_q;
    ones_d       = ones_q;
    tens_d       = tens_q;
    dneg_d       = dneg_q;
    conv_valid_d = conv_valid_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    seg_d        = SEG_BLANK;

    case (state_q)
      IDLE: begin
        if (!conv_valid_q || in_q != last_q) begin
          state_d = SHIFT;
          last_d  = in_q;
          neg_d   = in_neg;
          sr_d    = {8'd0, in_mag};
          iter_d  = 3'd0;
        end
      end
      SHIFT: begin
        sr_d   = dd_step(sr_q);
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd5) state_d = DONE;
      end
      DONE: begin
        ones_d       = sr_q[9:6];
        tens_d       = sr_q[13:10];
        dneg_d       = neg_q;
        conv_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Hold busy through the one IDLE cycle between back-to-back conversions.
    busy_d = (state_d != IDLE) || (state_q == DONE && in_d != last_q);

    if (cnt_q == CW'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    an_d = ~(4'b0001 << idx_d);
    if (conv_valid_d) begin
      case (idx_d)
        2'd0:    seg_d = seg_code(ones_d);
        2'd1:    seg_d = (tens_d == 4'd0) ? SEG_BLANK : seg_code(tens_d);
        2'd2:    seg_d = dneg_d ? SEG_MINUS : SEG_BLANK;
        default: seg_d = SEG_BLANK;
      endcase
    end
  end

  // Input register keeps sampling during reset so the first conversion sees the live input.
  always_ff @(posedge clk) begin
    in_q <= in_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= '0;
      sr_q         <= '0;
      iter_q       <= '0;
      neg_q        <= 1'b0;
      ones_q       <= '0;
      tens_q       <= '0;
      dneg_q       <= 1'b0;
      conv_valid_q <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      seg_q        <= SEG_BLANK;
      an_q         <= 4'b1111;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      sr_q         <= sr_d;
      iter_q       <= iter_d;
      neg_q        <= neg_d;
      ones_q       <= ones_d;
      tens_q       <= tens_d;
      dneg_q       <= dneg_d;
      conv_valid_q <= conv_valid_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      busy_q       <= busy_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = busy_q;
  assign dp   = 1'b1;

endmodule

// File: tb/tb_result_display.sv
// Bench for result_display: driver pushes expected digit patterns, a monitor scans
// the display after each completed conversion and compares.
module tb_result_display;
  localparam int DIV = 4;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] x = 6'd0;
  logic       signed_mode = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       busy;

  always #5 clk = ~clk;

  result_display #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .signed_mode(signed_mode),
    .seg(seg), .an(an), .dp(dp), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int mon_done = 0;
  logic [27:0] exp_q[$];
  logic [5:0] last_x;
  logic       last_sm;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return BLANK;
    endcase
  endfunction

  // Reference: decimal rendering of the value, packed {idx3, idx2, idx1, idx0}.
  function automatic logic [27:0] model(input logic [5:0] xv, input logic smv);
    int v, a, tens, ones;
    logic [6:0] s1, s2;
    if (smv) v = int'($signed(xv));
    else     v = int'(xv);
    a    = (v < 0) ? -v : v;
    tens = a / 10;
    ones = a % 10;
    s1 = (tens == 0) ? BLANK : seg_of(tens);
    s2 = (v < 0) ? MINUS : BLANK;
    return {BLANK, s2, s1, seg_of(ones)};
  endfunction

  // Monitor: after each busy fall, scan 16 cycles and compare all four digits.
  logic       mon_prev = 1'b0;
  logic [6:0] mon_g[4];
  logic [3:0] mon_seen;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_prev = 1'b0;
      end else if (mon_prev && !busy) begin
        mon_seen = 4'b0000;
        for (int k = 0; k < 4; k++) mon_g[k] = 7'h00;
        for (int k = 0; k < 16; k++) begin
          if (k > 0) @(negedge clk);
          case (an)
            4'b1110: begin mon_g[0] = seg; mon_seen[0] = 1'b1; end
            4'b1101: begin mon_g[1] = seg; mon_seen[1] = 1'b1; end
            4'b1011: begin mon_g[2] = seg; mon_seen[2] = 1'b1; end
            4'b0111: begin mon_g[3] = seg; mon_seen[3] = 1'b1; end
            default: check("an_onehot", {28'd0, an}, 32'he);
          endcase
        end
        check("scan_all_digits", {28'd0, mon_seen}, 32'hf);
        check("dp", {31'd0, dp}, 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_result", {mon_g[3], mon_g[2], mon_g[1], mon_g[0]}, 32'hffffffff);
        end else begin
          check("display", {mon_g[3], mon_g[2], mon_g[1], mon_g[0]}, exp_q.pop_front());
        end
        mon_done++;
        mon_prev = busy;
      end else begin
        mon_prev = busy;
      end
    end
  end

  task automatic wait_mon(input int start, input string name);
    int n;
    n = 0;
    while (mon_done == start && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, {31'd0, mon_done != start}, 32'd1);
  endtask

  task automatic run_case(input logic [5:0] xv, input logic smv, input string name);
    int start, n;
    logic seen;
    start = mon_done;
    x = xv;
    signed_mode = smv;
    last_x = xv;
    last_sm = smv;
    exp_q.push_back(model(xv, smv));
    n = 0;
    seen = 1'b0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (busy) seen = 1'b1;
      else if (seen) break;
    end
    check({name, "_latency_ok"}, {31'd0, (seen && !busy && n <= 10)}, 32'd1);
    wait_mon(start, name);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, start, hold;
    logic [3:0] cur;
    logic [5:0] rx;
    logic       rsm;

    // Reset state with x=0 signed.
    x = 6'd0;
    signed_mode = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_seg", {25'd0, seg}, 32'h7f);
    check("rst_an", {28'd0, an}, 32'hf);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dp", {31'd0, dp}, 32'd1);

    // Release: scanning resumes immediately, conversion of 0 takes 7 busy cycles.
    start = mon_done;
    last_x = 6'd0;
    last_sm = 1'b1;
    exp_q.push_back(model(6'd0, 1'b1));
    rst_n = 1'b1;
    @(negedge clk);
    check("first_an", {28'd0, an}, 32'he);
    n = busy ? 1 : 0;
    while (busy && n < 30) begin
      @(negedge clk);
      if (busy) n++;
    end
    check("busy_pulse_len", n, 32'd7);
    wait_mon(start, "zero");

    // Scan order and hold length.
    cur = an;
    n = 0;
    while (an == cur && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int g = 0; g < 5; g++) begin
      cur = an;
      hold = 0;
      while (an == cur && hold < 20) begin
        @(negedge clk);
        hold++;
      end
      check("scan_hold", hold, DIV);
      check("scan_order", {28'd0, an}, {28'd0, cur[2:0], cur[3]});
    end

    // Boundary values.
    run_case(6'b100000, 1'b1, "m32");
    run_case(6'b100000, 1'b0, "p32");
    run_case(6'b111111, 1'b0, "p63");
    run_case(6'b111111, 1'b1, "m1");

    // Random values, each different from the previous one.
    for (int i = 0; i < 12; i++) begin
      do begin
        rx  = 6'($urandom_range(0, 63));
        rsm = 1'($urandom_range(0, 1));
      end while (rx == last_x && rsm == last_sm);
      run_case(rx, rsm, "rand");
    end

    // Input change two cycles into SHIFT: one continuous busy window, ends on 17.
    run_case((last_x == 6'd40) ? 6'd41 : 6'd40, 1'b0, "pre_change");
    start = mon_done;
    x = 6'd5;
    signed_mode = 1'b0;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("change_busy_rise", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    x = 6'd17;
    exp_q.push_back(model(6'd17, 1'b0));
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("change_latency_ok", {31'd0, n <= 20}, 32'd1);
    wait_mon(start, "change");
    check("change_single_result", mon_done - start, 32'd1);

    // Reset during SHIFT aborts at once; the live input is shown after release.
    x = 6'd45;
    signed_mode = 1'b1;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_seg", {25'd0, seg}, 32'h7f);
    check("abort_an", {28'd0, an}, 32'hf);
    check("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("abort_hold_seg", {25'd0, seg}, 32'h7f);
    start = mon_done;
    exp_q.push_back(model(6'd45, 1'b1));
    rst_n = 1'b1;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (!busy && n > 1) break;
    end
    check("abort_latency_ok", {31'd0, n <= 10}, 32'd1);
    wait_mon(start, "abort");

    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
